// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: AES InvMixColumns over a 128-bit state.
// The state is loaded into a work register and transformed in place,
// COLS_PER_CYCLE columns per clock, then presented until downstream takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE after reset has been released for
// one edge. out_valid is high only in DONE, and out_data is held stable
// there until out_ready completes the transfer.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Column index of the final step; DONE is decoded from this, not from wrap.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Multiply by 02 in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; 09/0b/0d/0e are assembled from b, 2b, 4b, 8b.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] b  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      b[i]  = c[31-8*i -: 8];
      x2    = xtime(b[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ b[i];
      mb[i] = x8 ^ x2 ^ b[i];
      md[i] = x8 ^ x4 ^ b[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   work_q, work_d;
  logic           live_q, live_d;
  logic [1:0]     cidx;
  logic [6:0]     cbase;

  // in_ready waits one edge after reset release via live_q.
  assign in_ready  = (state_q == ST_IDLE) && live_q;
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = work_q;

  // Next-state, column counter and in-place column update.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    live_d  = 1'b1;
    cidx    = 2'd0;
    cbase   = 7'd127;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = in_data;
          col_d   = 2'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          cidx  = col_q + 2'(k);
          // Column c lives at bits 127-32c down; that MSB is {~c, 5'h1f}.
          cbase = {~cidx, 5'h1f};
          work_d[cbase -: 32] = inv_mix_col(work_q[cbase -: 32]);
        end
        if (col_q == LAST_COL) begin
          col_d   = 2'd0;
          state_d = ST_DONE;
        end else begin
          col_d = col_q + COL_STEP;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any partially transformed state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2, 4 columns per cycle)
// share clock, reset and in_data; one instance at a time is exercised.
module tb_inv_mix_columns_seq;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [N];
  logic         in_ready  [N];
  logic [127:0] in_data;
  logic         out_valid [N];
  logic         out_ready [N];
  logic [127:0] out_data  [N];

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int cyc    = 0;
  int acc_cyc;

  logic [127:0] exp_q[$];

  logic [31:0] vin  [6] = '{32'h01010101, 32'h8e4da1bc, 32'h9fdc589d,
                            32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6};
  logic [31:0] vout [6] = '{32'h01010101, 32'hdb135345, 32'hf20a225c,
                            32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6};
  logic [127:0] mixed_in  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_01010101;
  logic [127:0] mixed_out = 128'hdb135345_f20a225c_d4d4d4d5_01010101;

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_data   (in_data),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_data  (out_data[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Forward (encrypt-side) reference model.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: every completed output transfer of the selected instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid[sel] && out_ready[sel]) begin
      if (exp_q.size() == 0) check("spurious_out", 128'(out_valid[sel]), 128'(0));
      else check("sb_data", out_data[sel], exp_q.pop_front());
    end
  end

  // Offer d to instance i; while it is not ready, optionally toggle in_valid with junk.
  task automatic send(input int i, input logic [127:0] d, input logic [127:0] e,
                      input bit push, input bit jitter);
    int n = 0;
    @(negedge clk);
    while (!in_ready[i] && n < 200) begin
      if (jitter) begin
        in_valid[i] = 1'($urandom_range(0, 1));
        in_data     = rnd128();
      end
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("in_ready_timeout", 128'(in_ready[i]), 128'(1));
      in_valid[i] = 1'b0;
    end else begin
      in_valid[i] = 1'b1;
      in_data     = d;
      @(posedge clk);
      if (push) exp_q.push_back(e);
      #1;
      acc_cyc     = cyc;
      in_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_out(input int i);
    int n = 0;
    @(negedge clk);
    while (!out_valid[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("out_valid_timeout", 128'(out_valid[i]), 128'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", 128'(exp_q.size()), 128'(0));
  endtask

  // Watchdog.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int a0;
    rst_n   = 1'b0;
    in_data = '0;
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end

    // Reset values.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      check("rst_out_valid", 128'(out_valid[i]), 128'(0));
      check("rst_in_ready",  128'(in_ready[i]),  128'(0));
      check("rst_out_data",  out_data[i],        128'(0));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("pre_edge_in_ready", 128'(in_ready[0]), 128'(0));
    @(posedge clk); #1;
    check("post_rst_in_ready", 128'(in_ready[0]), 128'(1));

    // Known vectors and mixed-column state on every width, with latency.
    for (int i = 0; i < N; i++) begin
      sel = i;
      for (int v = 0; v < 6; v++) begin
        send(i, {4{vin[v]}}, {4{vout[v]}}, 1'b1, 1'b0);
        wait_out(i);
        check("latency_vec", 128'(cyc - acc_cyc), 128'(4 >> i));
        drain();
      end
      send(i, mixed_in, mixed_out, 1'b1, 1'b0);
      wait_out(i);
      check("latency_mixed", 128'(cyc - acc_cyc), 128'(4 >> i));
      drain();
    end

    // Backpressure on the single-column instance.
    sel = 0;
    @(posedge clk); #1 out_ready[0] = 1'b0;
    send(0, mixed_in, mixed_out, 1'b1, 1'b0);
    wait_out(0);
    repeat (10) begin
      check("bp_data",      out_data[0],        mixed_out);
      check("bp_out_valid", 128'(out_valid[0]), 128'(1));
      check("bp_in_ready",  128'(in_ready[0]),  128'(0));
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 128'(out_valid[0]), 128'(0));
    check("bp_release_ready", 128'(in_ready[0]),  128'(1));
    check("bp_sb_empty",      128'(exp_q.size()), 128'(0));

    // Reset while BUSY at column 2; nothing may be emitted.
    send(0, mixed_in, mixed_out, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_in_ready",  128'(in_ready[0]),  128'(0));
    check("mid_rst_out_data",  out_data[0],        128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_in_ready", 128'(in_ready[0]), 128'(1));
    repeat (5) begin
      @(negedge clk);
      check("after_rst_no_out", 128'(out_valid[0]), 128'(0));
    end
    send(0, {4{vin[4]}}, {4{vout[4]}}, 1'b1, 1'b0);
    wait_out(0);
    drain();

    // Back-to-back traffic at the minimum initiation interval.
    for (int i = 0; i < N; i++) begin
      sel = i;
      send(i, {4{vin[1]}}, {4{vout[1]}}, 1'b1, 1'b0);
      a0 = acc_cyc;
      send(i, {4{vin[2]}}, {4{vout[2]}}, 1'b1, 1'b0);
      check("min_ii", 128'(acc_cyc - a0), 128'((4 >> i) + 2));
      drain();
    end

    // Round trip: forward-mixed random states must come back unchanged.
    for (int i = 0; i < N; i++) begin
      sel = i;
      for (int n = 0; n < ((i == 0) ? 1000 : 100); n++) begin
        logic [127:0] x;
        x = rnd128();
        send(i, mix_state(x), x, 1'b1, 1'(n % 2));
      end
      drain();
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
